ula_controle: RTL and testbench
===============================

# ula_controle

Command-issuing front end for the `ULA_Final` ALU. It accepts operation commands (opcode, A, B) over a valid/ready interface and buffers them in a small FIFO. It drives the ALU's operand, opcode and control inputs one operation at a time, waits out the ALU's registered-output latency, and returns the 9-bit result over a second valid/ready interface. It is the initiator on the ALU port; the ALU is the responder.

## Interface
- `WIDTH`, 8: operand width; results are `WIDTH+1` bits.
- `LAT`, 1: ALU output-register latency in cycles, counted from the `EN` edge. Legal range is 1..7.
- `DEPTH`, 4: command FIFO depth, a power of two ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `CLR_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both are high at an edge.
- `cmd_op`  in  3  opcode.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `ula_A`, `ula_B`  out  WIDTH  ALU operands.
- `ula_OPCODE`  out  3  ALU opcode.
- `ula_EN`  out  1  ALU load enable.
- `ula_CLR`  out  1  ALU clear, active-high.
- `ula_PR`  out  1  ALU preset; tied to 0.
- `ula_s`  in  WIDTH+1  ALU registered result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when both are high at an edge.
- `res_data`  out  WIDTH+1  result.
- `res_op`  out  3  opcode of the result.
- `res_err`  out  1  result belongs to a reserved opcode.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.
- `ops_count`  out  8  completed result handshakes; wraps modulo 256.

## Operation
- Opcode map:
  - 001 SOMA
  - 010 SUB
  - 011 AND
  - 100 OR
  - 110 NOT A
  - 111 NOT B
  - 000 and 101 are reserved.
- FIFO behaviour:
  - `cmd_ready = !fifo_full`.
  - A push and a pop in the same cycle are both honoured.
  - When the FIFO is full, `cmd_ready` is low, so no push occurs even if a pop happens that cycle.
- FSM states are IDLE, ISSUE, WAIT and OUT.
  - IDLE: if the FIFO is non-empty, pop the head into the operand registers and go to ISSUE. A reserved opcode instead goes directly to OUT with `res_data = 0` and `res_err = 1`; it never pulses `ula_EN`.
  - ISSUE: `ula_EN = 1` for exactly this one cycle. Go to WAIT and load the wait counter with `LAT`.
  - WAIT: decrement the counter each cycle. On the edge where the counter reaches 0, register `ula_s` into `res_data`, set `res_err = 0`, and go to OUT.
  - OUT: `res_valid = 1`. Hold `res_data`, `res_op` and `res_err` stable until the handshake. On the handshake edge, increment `ops_count`; if the FIFO is non-empty, pop and go to ISSUE (or back to OUT for a reserved opcode), otherwise go to IDLE.
- At most one operation is in flight.
- Between operations, `ula_A`, `ula_B` and `ula_OPCODE` hold their last issued values and `ula_EN = 0`.
- `ula_CLR` is a register that resets to 1 and clears to 0 on the first edge after `CLR_n` deasserts.
- Reset values:
  - `res_valid`, `res_data`, `res_op`, `res_err`, `ula_A`, `ula_B`, `ula_EN`, `ops_count`: 0.
  - `ula_OPCODE`: 000.
  - FSM: IDLE; FIFO: empty.
  - `cmd_ready`: 1, combinational from the empty FIFO.
  - `busy`: 0.
- Reset asserted mid-operation discards both the in-flight operation and the FIFO contents. There is no partial result.

## Timing
- Latency for a command accepted at edge 0 into an idle, empty block:
  - FIFO non-empty after edge 0.
  - Pop and move to ISSUE at edge 1.
  - `ula_EN` high during cycle 1→2; the ALU loads at edge 2.
  - `ula_s` is sampled at edge 2+`LAT`, and `res_valid` rises at that edge.
  - For `LAT = 1`, `res_valid` rises at edge 3.
- A reserved opcode accepted at edge 0 gives `res_valid` at edge 1.
- Back-to-back throughput with `res_ready` tied high: one result every `LAT + 2` cycles.
- `res_valid` never drops without a handshake.
- `cmd_ready` and `res_valid` have no combinational path from `cmd_valid` or `res_ready`.

## Structure
- Shared header `ula_defs.vh` holds:
  - the opcode localparams `OP_SOMA`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_NOTA`, `OP_NOTB`;
  - the FSM state encodings;
  - the `is_reserved` opcode check.
  The ALU and this block both include it.
- One sub-module, `ula_cmd_fifo`, parameterized on the data width (`2*WIDTH+3`) and `DEPTH`. It provides full/empty flags and async active-low reset.

## Test plan
- SOMA, A=8'h04, B=8'h03, `res_ready` = 1 → `ula_EN` pulses once; `res_valid` at edge 3 after accept; `res_data` = 9'h007; `res_op` = 001; `ops_count` = 1.
- Sequence SUB 8'h08,8'h02; AND 8'hAA,8'hCC; OR 8'hAA,8'hCC, pushed back-to-back → results 9'h006, 9'h088, 9'h0EE, in order, spaced `LAT + 2` cycles apart.
- `res_ready` = 0, push 6 commands → 5 accepted (1 popped plus 4 buffered); `cmd_ready` low on the 6th; `res_data` stable while stalled. Release → all 5 results drain in order.
- Opcode 101 → `res_err` = 1, `res_data` = 0, `res_valid` one edge after pop, `ula_EN` never asserted.
- `CLR_n` pulsed low during WAIT → all outputs return to reset values immediately; `ula_CLR` = 1 until the first edge after release; no result is emitted for the flushed commands.
- 256 handshakes → `ops_count` wraps to 0.

Source files
------------

// File: rtl/ula_controle_pkg.sv
// Shared opcode map, FSM state encodings and opcode helpers for the ULA_Final
// ALU and its command front end.
package ula_controle_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_SOMA = 3'b001;
    localparam opcode_t OP_SUB  = 3'b010;
    localparam opcode_t OP_AND  = 3'b011;
    localparam opcode_t OP_OR   = 3'b100;
    localparam opcode_t OP_NOTA = 3'b110;
    localparam opcode_t OP_NOTB = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // 000 and 101 have no ALU meaning; they are answered locally with an error.
    function automatic logic is_reserved(input opcode_t op);
        return (op == 3'b000) || (op == 3'b101);
    endfunction

endpackage

// File: rtl/ula_cmd_fifo.sv
// Small command FIFO with full/empty flags; simultaneous push and pop are both
// honoured, and a push into a full FIFO or a pop from an empty one is ignored.
module ula_cmd_fifo #(
    parameter int DW    = 19,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          CLR_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ula_controle.sv
// Command-issuing front end for the ULA_Final ALU: buffers commands, issues one
// ALU operation at a time, waits out the ALU latency and returns the result.
module ula_controle
    import ula_controle_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             CLR_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] ula_A,
    output logic [WIDTH-1:0] ula_B,
    output logic [2:0]       ula_OPCODE,
    output logic             ula_EN,
    output logic             ula_CLR,
    output logic             ula_PR,
    input  logic [WIDTH:0]   ula_s,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_data,
    output logic [2:0]       res_op,
    output logic             res_err,
    output logic             busy,
    output logic [7:0]       ops_count
);

    localparam int         DW      = 2*WIDTH + 3;
    localparam logic [2:0] LAT_CNT = 3'(LAT);

    logic [1:0]       state;
    logic [2:0]       cnt;
    logic [DW-1:0]    fifo_wdata;
    logic [DW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             take;
    logic             handshake;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    assign fifo_wdata = {cmd_op, cmd_a, cmd_b};
    assign head_op    = fifo_rdata[DW-1 -: 3];
    assign head_a     = fifo_rdata[2*WIDTH-1 -: WIDTH];
    assign head_b     = fifo_rdata[WIDTH-1:0];

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign res_valid  = (state == ST_OUT);
    assign handshake  = res_valid && res_ready;
    // A new command is taken from IDLE, or straight out of OUT on the handshake edge.
    assign take       = !fifo_empty && ((state == ST_IDLE) || handshake);
    assign ula_EN     = (state == ST_ISSUE);
    assign ula_PR     = 1'b0;
    assign busy       = !fifo_empty || (state != ST_IDLE);

    ula_cmd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .CLR_n (CLR_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (take),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            ula_CLR   <= 1'b1;
            ops_count <= '0;
        end else begin
            ula_CLR <= 1'b0;
            if (handshake) begin
                ops_count <= ops_count + 8'd1;
            end
        end
    end

    // Reserved opcodes skip the ALU entirely and leave the ALU operand registers untouched.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ula_A      <= '0;
            ula_B      <= '0;
            ula_OPCODE <= 3'b000;
            res_data   <= '0;
            res_op     <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_OUT: begin
                    if (take) begin
                        res_op <= head_op;
                        if (is_reserved(head_op)) begin
                            res_data <= '0;
                            res_err  <= 1'b1;
                            state    <= ST_OUT;
                        end else begin
                            ula_A      <= head_a;
                            ula_B      <= head_b;
                            ula_OPCODE <= head_op;
                            state      <= ST_ISSUE;
                        end
                    end else if (handshake) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                    cnt   <= LAT_CNT;
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        res_data <= ula_s;
                        res_err  <= 1'b0;
                        state    <= ST_OUT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_controle.sv
// Directed testbench for ula_controle with a behavioural one-cycle-latency ALU.
module tb_ula_controle;

    localparam int WIDTH = 8;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             CLR_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] ula_A;
    logic [WIDTH-1:0] ula_B;
    logic [2:0]       ula_OPCODE;
    logic             ula_EN;
    logic             ula_CLR;
    logic             ula_PR;
    logic [WIDTH:0]   ula_s;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH:0]   res_data;
    logic [2:0]       res_op;
    logic             res_err;
    logic             busy;
    logic [7:0]       ops_count;

    int n_cmp = 0;
    int n_bad = 0;
    int en_pulses = 0;

    always #5 clk = ~clk;

    ula_controle #(
        .WIDTH (WIDTH),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .CLR_n      (CLR_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .ula_A      (ula_A),
        .ula_B      (ula_B),
        .ula_OPCODE (ula_OPCODE),
        .ula_EN     (ula_EN),
        .ula_CLR    (ula_CLR),
        .ula_PR     (ula_PR),
        .ula_s      (ula_s),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_err    (res_err),
        .busy       (busy),
        .ops_count  (ops_count)
    );

    // Behavioural ALU: result register loads on EN, cleared by CLR.
    function automatic logic [WIDTH:0] alu_fn(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (op)
            3'b001:  return {1'b0, a} + {1'b0, b};
            3'b010:  return {1'b0, a} - {1'b0, b};
            3'b011:  return {1'b0, a & b};
            3'b100:  return {1'b0, a | b};
            3'b110:  return {1'b0, ~a};
            3'b111:  return {1'b0, ~b};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge ula_CLR) begin
        if (ula_CLR) ula_s <= '0;
        else if (ula_EN) ula_s <= alu_fn(ula_OPCODE, ula_A, ula_B);
    end

    always @(negedge clk) begin
        if (ula_EN === 1'b1) en_pulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        CLR_n = 1'b0;
        #12;
        n_cmp++;
        if ({res_valid, res_err, res_op, res_data} !== 13'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_res: got %b/%b/%b/%h expected 0/0/000/000", res_valid, res_err, res_op, res_data);
        end
        n_cmp++;
        if ({ula_A, ula_B, ula_OPCODE, ula_EN, ula_PR} !== 21'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_ula: got A=%h B=%h OP=%b EN=%b PR=%b expected all zero", ula_A, ula_B, ula_OPCODE, ula_EN, ula_PR);
        end
        n_cmp++;
        if ({cmd_ready, busy, ula_CLR, ops_count} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            n_bad++;
            $display("[TB] FAIL reset_misc: got ready=%b busy=%b clr=%b cnt=%0d expected 1/0/1/0", cmd_ready, busy, ula_CLR, ops_count);
        end
        @(negedge clk);
        CLR_n = 1'b1;
        #1;
        n_cmp++;
        if (ula_CLR !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL clr_hold: got %b expected 1", ula_CLR);
        end
        tick();
        n_cmp++;
        if (ula_CLR !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL clr_release: got %b expected 0", ula_CLR);
        end
    endtask

    task automatic test_soma;
        int base;
        base      = en_pulses;
        res_ready = 1'b1;
        cmd_op    = 3'b001;
        cmd_a     = 8'h04;
        cmd_b     = 8'h03;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL soma_e0: got valid=%b busy=%b expected 0/1", res_valid, busy);
        end
        tick();
        n_cmp++;
        if ({ula_EN, ula_OPCODE, ula_A, ula_B} !== {1'b1, 3'b001, 8'h04, 8'h03}) begin
            n_bad++;
            $display("[TB] FAIL soma_issue: got EN=%b OP=%b A=%h B=%h expected 1/001/04/03", ula_EN, ula_OPCODE, ula_A, ula_B);
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b0 || ula_EN !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL soma_e2: got valid=%b EN=%b expected 0/0", res_valid, ula_EN);
        end
        tick();
        n_cmp++;
        if ({res_valid, res_data, res_op, res_err} !== {1'b1, 9'h007, 3'b001, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL soma_result: got v=%b d=%h op=%b err=%b expected 1/007/001/0", res_valid, res_data, res_op, res_err);
        end
        tick();
        n_cmp++;
        if (ops_count !== 8'd1 || res_valid !== 1'b0 || (en_pulses - base) != 1) begin
            n_bad++;
            $display("[TB] FAIL soma_done: got cnt=%0d valid=%b pulses=%0d expected 1/0/1", ops_count, res_valid, en_pulses - base);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]       ops  [3] = '{3'b010, 3'b011, 3'b100};
        logic [WIDTH-1:0] as   [3] = '{8'h08, 8'hAA, 8'hAA};
        logic [WIDTH-1:0] bs   [3] = '{8'h02, 8'hCC, 8'hCC};
        logic [WIDTH:0]   exp  [3] = '{9'h006, 9'h088, 9'h0EE};
        logic [WIDTH:0]   got  [3];
        int               at   [3];
        int               nres = 0;
        res_ready = 1'b1;
        for (int e = 0; e < 30; e++) begin
            if (e < 3) begin
                cmd_op    = ops[e];
                cmd_a     = as[e];
                cmd_b     = bs[e];
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (res_valid === 1'b1) begin
                if (nres < 3) begin
                    got[nres] = res_data;
                    at[nres]  = e;
                end
                nres++;
            end
        end
        n_cmp++;
        if (nres != 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_count: got %0d results expected 3", nres);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got[i] !== exp[i]) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
            n_cmp++;
            if (at[0] != 2 + LAT || at[1] - at[0] != LAT + 2 || at[2] - at[1] != LAT + 2) begin
                n_bad++;
                $display("[TB] FAIL b2b_spacing: got edges %0d,%0d,%0d expected 3,6,9", at[0], at[1], at[2]);
            end
        end
    endtask

    task automatic test_backpressure;
        int accepted = 0;
        int nres = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_op    = 3'b001;
            cmd_a     = 8'(i + 1);
            cmd_b     = 8'h10;
            cmd_valid = 1'b1;
            if (cmd_ready === 1'b1) accepted++;
            if (i == 5) begin
                n_cmp++;
                if (cmd_ready !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL bp_sixth_ready: got %b expected 0", cmd_ready);
                end
            end
            tick();
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (accepted != 5) begin
            n_bad++;
            $display("[TB] FAIL bp_accepted: got %0d expected 5", accepted);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 9'h011 || res_op !== 3'b001) begin
                n_bad++;
                $display("[TB] FAIL bp_stall%0d: got v=%b d=%h op=%b expected 1/011/001", c, res_valid, res_data, res_op);
            end
        end
        res_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (res_valid === 1'b1) begin
                n_cmp++;
                if (res_data !== 9'h011 + 9'(nres)) begin
                    n_bad++;
                    $display("[TB] FAIL bp_drain%0d: got %h expected %h", nres, res_data, 9'h011 + 9'(nres));
                end
                nres++;
            end
            tick();
        end
        n_cmp++;
        if (nres != 5 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL bp_drain_count: got %0d results busy=%b expected 5/0", nres, busy);
        end
    endtask

    task automatic test_reserved;
        int base;
        base      = en_pulses;
        res_ready = 1'b1;
        cmd_op    = 3'b101;
        cmd_a     = 8'h5A;
        cmd_b     = 8'hA5;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rsv_e0: got valid=%b expected 0", res_valid);
        end
        tick();
        n_cmp++;
        if ({res_valid, res_err, res_data, res_op} !== {1'b1, 1'b1, 9'h000, 3'b101}) begin
            n_bad++;
            $display("[TB] FAIL rsv_result: got v=%b err=%b d=%h op=%b expected 1/1/000/101", res_valid, res_err, res_data, res_op);
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b0 || en_pulses != base || ops_count !== 8'd10) begin
            n_bad++;
            $display("[TB] FAIL rsv_done: got v=%b pulses=%0d cnt=%0d expected 0/0/10", res_valid, en_pulses - base, ops_count);
        end
        n_cmp++;
        if ({ula_OPCODE, ula_A, ula_B} !== {3'b001, 8'h05, 8'h10}) begin
            n_bad++;
            $display("[TB] FAIL rsv_ula_hold: got OP=%b A=%h B=%h expected 001/05/10", ula_OPCODE, ula_A, ula_B);
        end
    endtask

    task automatic test_reset_midop;
        int seen = 0;
        res_ready = 1'b1;
        cmd_op    = 3'b001;
        cmd_a     = 8'h01;
        cmd_b     = 8'h02;
        cmd_valid = 1'b1;
        tick();
        cmd_op    = 3'b010;
        cmd_a     = 8'h09;
        cmd_b     = 8'h01;
        tick();
        cmd_valid = 1'b0;
        tick();
        #2;
        CLR_n = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, busy, cmd_ready, ula_CLR, ula_EN} !== 5'b00110) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_ctrl: got v=%b busy=%b ready=%b clr=%b en=%b expected 0/0/1/1/0", res_valid, busy, cmd_ready, ula_CLR, ula_EN);
        end
        n_cmp++;
        if ({ula_A, ula_B, ula_OPCODE, ops_count, res_data} !== 36'h0) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_regs: got A=%h B=%h OP=%b cnt=%0d d=%h expected all zero", ula_A, ula_B, ula_OPCODE, ops_count, res_data);
        end
        @(negedge clk);
        CLR_n = 1'b1;
        #1;
        n_cmp++;
        if (ula_CLR !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_clr_hold: got %b expected 1", ula_CLR);
        end
        tick();
        n_cmp++;
        if (ula_CLR !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_clr_rel: got %b expected 0", ula_CLR);
        end
        for (int c = 0; c < 10; c++) begin
            if (res_valid !== 1'b0) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0 || busy !== 1'b0 || ops_count !== 8'd0) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_flush: got %0d results busy=%b cnt=%0d expected 0/0/0", seen, busy, ops_count);
        end
    endtask

    task automatic test_wrap;
        int acc = 0;
        int hs = 0;
        int cyc = 0;
        bit checked255 = 0;
        res_ready = 1'b1;
        cmd_op    = 3'b000;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        while (hs < 256 && cyc < 3000) begin
            cmd_valid = (acc < 256);
            if (cmd_valid && cmd_ready === 1'b1) acc++;
            if (res_valid === 1'b1 && res_ready) hs++;
            tick();
            cyc++;
            if (hs == 255 && !checked255) begin
                checked255 = 1;
                n_cmp++;
                if (ops_count !== 8'd255) begin
                    n_bad++;
                    $display("[TB] FAIL wrap_255: got %0d expected 255", ops_count);
                end
            end
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (hs != 256) begin
            n_bad++;
            $display("[TB] FAIL wrap_timeout: got %0d handshakes expected 256", hs);
        end
        n_cmp++;
        if (ops_count !== 8'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL wrap_zero: got cnt=%0d busy=%b expected 0/0", ops_count, busy);
        end
    endtask

    initial begin
        CLR_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b0;
        test_reset();
        test_soma();
        test_back_to_back();
        test_backpressure();
        test_reserved();
        test_reset_midop();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
